add16u_arbiter: RTL
===================

# add16u_arbiter

Round-robin arbiter and result buffer that time-shares one exact 16-bit unsigned adder among `NREQ` requesters. It sits between several independent producers, each with a valid/ready request port, and a single registered response port. Each accepted request gets its 17-bit sum and the requester's index one cycle after acceptance. Fairness is guaranteed: no requester waits more than `NREQ-1` grants once valid.

## Interface
- `NREQ`, default 4: number of requesters, 2..8.
- `IDW`, default `$clog2(NREQ)`: width of the requester index. Derived; not overridden.
- `clk` input, 1 bit: single clock; all state updates on its rising edge.
- `rst_n` input, 1 bit: reset is synchronous and active-low.
- `req_valid` input, `NREQ` bits: per-requester request valid.
- `req_ready` output, `NREQ` bits: per-requester accept; at most one bit set (one-hot grant).
- `req_a` input, `NREQ*16` bits: operand A. Requester i uses bits `[16i+15:16i]`.
- `req_b` input, `NREQ*16` bits: operand B, packed the same way as `req_a`.
- `rsp_valid` output, 1 bit: response register holds a result.
- `rsp_ready` input, 1 bit: consumer accepts the response.
- `rsp_sum` output, 17 bits: A+B. Bit 16 is the carry-out.
- `rsp_id` output, `IDW` bits: index of the requester that produced `rsp_sum`.
- `grant_cnt` output, 16 bits: total accepted requests since reset. Wraps modulo 2^16.

## Operation
- **States:**
  - EMPTY: response register invalid.
  - FULL: `rsp_valid`=1.
- **Slot free:** `slot_free` = EMPTY, or (FULL and `rsp_ready`).
- **Arbitration (combinational):**
  - Search order starts at index `ptr` and continues `ptr+1, …, NREQ-1, 0, …`.
  - The winner is the first i with `req_valid[i]`=1.
  - `req_ready[winner]` = `slot_free`; all other bits 0.
  - `req_ready` does not depend on `req_ready` itself. It depends on `req_valid`, `ptr`, state and `rsp_ready` only.
- **Handshake:**
  - A transfer occurs on requester i when `req_valid[i]` and `req_ready[i]` are both 1.
  - A requester holds valid, A and B stable until it is accepted.
  - Dropping valid before acceptance is illegal; bench assertion.
- **On accept of requester g:**
  - The adder core computes `req_a[g]+req_b[g]`.
  - The result is registered into `rsp_sum`, and g into `rsp_id`.
  - State goes to FULL.
  - `ptr` becomes (g+1) mod `NREQ`.
  - `grant_cnt` increments by 1.
- **Drain without new accept:** FULL and `rsp_ready` and no winner → EMPTY. `rsp_sum` and `rsp_id` hold their last values.
- **Simultaneous drain and accept:** the register is overwritten with the new result and stays FULL. This is back-to-back operation.
- **Back-pressure:** FULL and not `rsp_ready` means:
  - all `req_ready`=0;
  - `rsp_*` held stable;
  - `ptr` unchanged.
- **Pointer stability:** `ptr` changes only on a grant. An idle cycle does not advance it.
- **Reset (`rst_n`=0 at a rising edge):**
  - `rsp_valid`=0, `rsp_sum`=0, `rsp_id`=0, `grant_cnt`=0, `ptr`=0, state EMPTY.
  - `req_ready` is forced to 0 while `rst_n`=0.
  - Reset mid-operation discards any buffered result; no response is issued for it.
- **Arithmetic:** exact unsigned, 16+16 → 17 bits. No saturation or truncation.

## Timing
- **Latency:** a request accepted at edge t gives `rsp_valid`=1 with its result from just after edge t, visible in cycle t+1.
- **Throughput:** one result per cycle while any `req_valid` is set and `rsp_ready`=1.
- **Combinational paths:**
  - `req_a`/`req_b` → adder → `rsp_sum` register is the critical path, one adder delay.
  - `rsp_ready` → `req_ready` is combinational, through `slot_free`.
- **Fairness bound:** a continuously valid requester is granted within `NREQ` grants.

## Structure
- **Package `add16u_arb_pkg`:**
  - constant `ADD_W`=16;
  - constant `SUM_W`=17;
  - state enum {EMPTY, FULL}.
- **Sub-module `add16u_core`:** one instance of the team's exact 16-bit unsigned adder. Ports A, B, O; O is 17 bits.
  - Only the selected requester's operands are muxed into it.
  - The core is swappable for an approximate variant without touching the arbiter.
- **Top-level logic:** round-robin priority logic, the operand mux, and the response register.

## Test plan
- **Reset:** hold `rst_n`=0 for 3 cycles with all `req_valid`=1.
  - Required: `req_ready`=0, `rsp_valid`=0, `grant_cnt`=0.
  - After release: first grant is requester 0.
- **Single request:** requester 2 sends A=0xFFFF, B=0x0001, `rsp_ready`=1.
  - Required: `rsp_sum`=0x10000, `rsp_id`=2 in the next cycle.
  - Then EMPTY, with `ptr`=3.
- **Round robin:** all 4 requesters valid continuously, requester i sending A=i, B=0x8000, `rsp_ready`=1.
  - Required: `rsp_id` sequence 0,1,2,3,0,… at one result per cycle.
  - `rsp_sum`=0x8000+i.
  - `grant_cnt`=8 after 8 cycles.
- **Back-pressure:** requesters 1 and 3 valid with `rsp_ready`=0 for 5 cycles.
  - Required: first result held stable, `req_ready`=0 throughout.
  - On `rsp_ready`=1: next result is requester 3 in the same-cycle drain+accept.
- **Mid-operation reset:** assert `rst_n`=0 while FULL with `rsp_sum`=0x1FFFE (A=B=0xFFFF).
  - Required: next cycle `rsp_valid`=0, `rsp_sum`=0, `ptr`=0.
- **Random:** 10k random operands and valid/ready patterns, checked against a reference model.
  - Per-requester ordering and exact sums.
  - No requester waits more than `NREQ` grants.
  - Total responses = `grant_cnt`.

Source files
------------

// File: rtl/add16u_arb_pkg.sv
// rtl/add16u_arb_pkg.sv - shared widths and buffer state for the add16u arbiter
//
// Purpose : operand/sum widths and the response-buffer state enum used by
//           add16u_arbiter and add16u_core.
// Contents: ADD_W (operand width), SUM_W (sum width incl. carry-out),
//           buf_state_t {EMPTY, FULL}.
package add16u_arb_pkg;

  localparam int ADD_W = 16;
  localparam int SUM_W = 17;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } buf_state_t;

endpackage

// File: rtl/add16u_core.sv
// rtl/add16u_core.sv - exact 16-bit unsigned adder core
//
// Purpose : combinational 16+16 -> 17 bit unsigned add. Kept as its own
//           module so an approximate adder with the same ports can be
//           dropped in without touching the arbiter.
// Ports   : A [ADD_W-1:0] operand A
//           B [ADD_W-1:0] operand B
//           O [SUM_W-1:0] A+B, O[16] is the carry-out
module add16u_core
  import add16u_arb_pkg::*;
(
  input  logic [ADD_W-1:0] A,
  input  logic [ADD_W-1:0] B,
  output logic [SUM_W-1:0] O
);

  assign O = {1'b0, A} + {1'b0, B};

endmodule

// File: rtl/add16u_arbiter.sv
// rtl/add16u_arbiter.sv - round-robin arbiter sharing one adder among NREQ requesters
//
// Purpose : picks one valid requester per cycle in round-robin order, feeds
//           its operands through a single add16u_core and registers the sum
//           and requester index into a one-entry response buffer.
// Ports   : clk        clock, all state on rising edge
//           rst_n      synchronous active-low reset
//           req_valid  [NREQ]      per-requester request valid
//           req_ready  [NREQ]      one-hot accept
//           req_a      [NREQ*16]   operand A, requester i at [16i+15:16i]
//           req_b      [NREQ*16]   operand B, same packing
//           rsp_valid  response buffer holds a result
//           rsp_ready  consumer takes the response
//           rsp_sum    [17]        A+B of the buffered result
//           rsp_id     [IDW]       requester index of the buffered result
//           grant_cnt  [16]        accepted requests since reset, wrapping
module add16u_arbiter
  import add16u_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*ADD_W-1:0] req_a,
  input  logic [NREQ*ADD_W-1:0] req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [SUM_W-1:0]      rsp_sum,
  output logic [IDW-1:0]        rsp_id,
  output logic [15:0]           grant_cnt
);

  buf_state_t       state;
  buf_state_t       state_next;
  logic [IDW-1:0]   ptr;
  logic [IDW-1:0]   ptr_next;
  logic [IDW-1:0]   winner;
  logic             found;
  logic             slot_free;
  logic             grant;
  logic [ADD_W-1:0] op_a;
  logic [ADD_W-1:0] op_b;
  logic [SUM_W-1:0] core_sum;

  // The buffer can take a new result when empty, or when its current
  // result leaves this same cycle.
  assign slot_free = (state == EMPTY) || rsp_ready;
  assign grant     = rst_n && found && slot_free;
  assign rsp_valid = (state == FULL);

  // Round-robin search starting at ptr. Uses only req_valid and ptr, so
  // req_ready never feeds back on itself.
  always_comb begin : rr_search
    int idx;
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) begin
        idx = idx - NREQ;
      end
      if (!found && req_valid[IDW'(idx)]) begin
        found  = 1'b1;
        winner = IDW'(idx);
      end
    end
  end

  // One-hot accept and operand mux for the winner only.
  always_comb begin : grant_mux
    req_ready = '0;
    op_a      = '0;
    op_b      = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (winner == IDW'(i)) begin
        req_ready[i] = grant;
        op_a         = req_a[i*ADD_W +: ADD_W];
        op_b         = req_b[i*ADD_W +: ADD_W];
      end
    end
  end

  add16u_core u_core (
    .A (op_a),
    .B (op_b),
    .O (core_sum)
  );

  // Pointer moves past the winner; idle cycles leave it where it is.
  assign ptr_next = (winner == IDW'(NREQ - 1)) ? '0 : winner + 1'b1;

  always_comb begin : state_logic
    state_next = state;
    if (grant) begin
      state_next = FULL;
    end else if ((state == FULL) && rsp_ready) begin
      state_next = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= EMPTY;
      ptr       <= '0;
      rsp_sum   <= '0;
      rsp_id    <= '0;
      grant_cnt <= '0;
    end else begin
      state <= state_next;
      if (grant) begin
        rsp_sum   <= core_sum;
        rsp_id    <= winner;
        ptr       <= ptr_next;
        grant_cnt <= grant_cnt + 16'd1;
      end
    end
  end

endmodule
